// File: rtl/stream_demux_1_to_n.sv
// Registered 1-to-N stream demultiplexer with per-channel valid/ready outputs.
// Optional out-of-range select counter enabled by STREAM_DEMUX_ERR_CNT_EN.
module stream_demux_1_to_n #(
  parameter int N = 8,
  parameter int M = 3,
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     in_data,
  input  logic [M-1:0]     in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N*W-1:0]   out_data,
  output logic [N-1:0]     out_valid,
  input  logic [N-1:0]     out_ready
`ifdef STREAM_DEMUX_ERR_CNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  localparam logic [31:0] NU = 32'(N);

  logic           s_valid_q, s_valid_d;
  logic [W-1:0]   s_data_q, s_data_d;
  logic [M-1:0]   s_sel_q, s_sel_d;
  logic [N-1:0]   ch_valid_q, ch_valid_d;
  logic [N*W-1:0] ch_data_q, ch_data_d;

  logic [31:0]    sel_ext;
  logic [N-1:0]   route_vec;
  logic           route;
  logic           drop;
  logic           in_fire;

  // Routing decision depends only on registered state and out_ready.
  always_comb begin
    sel_ext = 32'(s_sel_q);
    drop    = s_valid_q && (sel_ext >= NU);
    for (int i = 0; i < N; i++) begin
      route_vec[i] = s_valid_q && (sel_ext == 32'(i)) &&
                     (!ch_valid_q[i] || out_ready[i]);
    end
    route    = |route_vec;
    in_ready = !s_valid_q || route || drop;
    in_fire  = in_valid && in_ready;
  end

  always_comb begin
    s_valid_d  = s_valid_q;
    s_data_d   = s_data_q;
    s_sel_d    = s_sel_q;
    ch_valid_d = ch_valid_q;
    ch_data_d  = ch_data_q;

    if (in_fire) begin
      s_valid_d = 1'b1;
      s_data_d  = in_data;
      s_sel_d   = in_sel;
    end else if (route || drop) begin
      s_valid_d = 1'b0;
    end

    // A route into a draining channel reloads it in the same cycle.
    for (int i = 0; i < N; i++) begin
      if (route_vec[i]) begin
        ch_valid_d[i]         = 1'b1;
        ch_data_d[i*W +: W]   = s_data_q;
      end else if (out_ready[i] && ch_valid_q[i]) begin
        ch_valid_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_valid_q  <= 1'b0;
      s_data_q   <= '0;
      s_sel_q    <= '0;
      ch_valid_q <= '0;
      ch_data_q  <= '0;
    end else begin
      s_valid_q  <= s_valid_d;
      s_data_q   <= s_data_d;
      s_sel_q    <= s_sel_d;
      ch_valid_q <= ch_valid_d;
      ch_data_q  <= ch_data_d;
    end
  end

  assign out_valid = ch_valid_q;
  assign out_data  = ch_data_q;

`ifdef STREAM_DEMUX_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Saturating count of discarded words.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (drop && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_stream_demux_1_to_n.sv
// Bench for stream_demux_1_to_n: an N=8 instance for directed vectors and an
// N=5 instance for illegal selects plus randomized traffic against a scoreboard.
module tb_stream_demux_1_to_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  // N=8 instance
  logic [7:0]  in_data8;
  logic [2:0]  in_sel8;
  logic        in_valid8;
  logic        in_ready8;
  logic [63:0] out_data8;
  logic [7:0]  out_valid8;
  logic [7:0]  out_ready8;
  // N=5 instance
  logic [7:0]  in_data5;
  logic [2:0]  in_sel5;
  logic        in_valid5;
  logic        in_ready5;
  logic [39:0] out_data5;
  logic [4:0]  out_valid5;
  logic [4:0]  out_ready5;
`ifdef STREAM_DEMUX_ERR_CNT_EN
  logic [7:0]  err8;
  logic [7:0]  err5;
`endif

  stream_demux_1_to_n #(.N(8), .M(3), .W(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data8), .in_sel(in_sel8), .in_valid(in_valid8), .in_ready(in_ready8),
    .out_data(out_data8), .out_valid(out_valid8), .out_ready(out_ready8)
`ifdef STREAM_DEMUX_ERR_CNT_EN
    , .err_cnt(err8)
`endif
  );

  stream_demux_1_to_n #(.N(5), .M(3), .W(8)) dut5 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data5), .in_sel(in_sel5), .in_valid(in_valid5), .in_ready(in_ready5),
    .out_data(out_data5), .out_valid(out_valid5), .out_ready(out_ready5)
`ifdef STREAM_DEMUX_ERR_CNT_EN
    , .err_cnt(err5)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       iv;
    logic [2:0] sel;
    logic [7:0] d;
    logic [7:0] ordy;
    logic       exp_irdy;
    logic [7:0] exp_ov;
    int         ch;
    logic [7:0] exp_d;
  } vec_t;

  typedef struct packed {
    logic [2:0] sel;
    logic [7:0] d;
  } rec_t;

  vec_t       tbl [12];
  rec_t       sb [$];
  int         drops;
  logic [4:0] hold_v;
  logic [7:0] hold_d [5];

  // Scoreboard: per-channel FIFO order recovered from one global arrival list.
  task automatic mon5();
    int idx;
    for (int i = 0; i < 5; i++) begin
      if (hold_v[i]) begin
        chk("stable_valid", 64'(out_valid5[i]), 64'd1);
        chk("stable_data", 64'(out_data5[i*8 +: 8]), 64'(hold_d[i]));
      end
    end
    for (int i = 0; i < 5; i++) begin
      if (out_valid5[i] && out_ready5[i]) begin
        idx = -1;
        for (int j = 0; j < sb.size(); j++) begin
          if (idx < 0 && sb[j].sel == 3'(i)) idx = j;
        end
        if (idx < 0) begin
          tests++;
          fails++;
          $display("FAIL rand_unexpected: channel %0d delivered %0h with nothing pending", i,
                   out_data5[i*8 +: 8]);
        end else begin
          chk("rand_data", 64'(out_data5[i*8 +: 8]), 64'(sb[idx].d));
          sb.delete(idx);
        end
      end
    end
    if (sb.size() == 0) chk("rand_idle_ready", 64'(in_ready5), 64'd1);
    if (in_valid5 && in_ready5) begin
      if (in_sel5 < 3'd5) sb.push_back('{sel: in_sel5, d: in_data5});
      else drops++;
    end
    for (int i = 0; i < 5; i++) begin
      hold_v[i] = out_valid5[i] && !out_ready5[i];
      hold_d[i] = out_data5[i*8 +: 8];
    end
  endtask

  initial begin
    logic any_ov;
    rst_n = 1'b0;
    in_data8 = '0; in_sel8 = '0; in_valid8 = 1'b0; out_ready8 = '1;
    in_data5 = '0; in_sel5 = '0; in_valid5 = 1'b0; out_ready5 = '1;

    tbl[0]  = '{1'b1, 3'd5, 8'hA5, 8'hFF, 1'b1, 8'h00, 0, 8'h00};
    tbl[1]  = '{1'b0, 3'd0, 8'h00, 8'hFF, 1'b1, 8'h00, 0, 8'h00};
    tbl[2]  = '{1'b0, 3'd0, 8'h00, 8'hFF, 1'b1, 8'h20, 5, 8'hA5};
    tbl[3]  = '{1'b0, 3'd0, 8'h00, 8'hFF, 1'b1, 8'h00, 0, 8'h00};
    tbl[4]  = '{1'b1, 3'd3, 8'h11, 8'h00, 1'b1, 8'h00, 0, 8'h00};
    tbl[5]  = '{1'b1, 3'd3, 8'h22, 8'h00, 1'b1, 8'h00, 0, 8'h00};
    tbl[6]  = '{1'b1, 3'd3, 8'h33, 8'h00, 1'b0, 8'h08, 3, 8'h11};
    tbl[7]  = '{1'b1, 3'd3, 8'h33, 8'h00, 1'b0, 8'h08, 3, 8'h11};
    tbl[8]  = '{1'b1, 3'd3, 8'h33, 8'h08, 1'b1, 8'h08, 3, 8'h11};
    tbl[9]  = '{1'b0, 3'd3, 8'h00, 8'h08, 1'b1, 8'h08, 3, 8'h22};
    tbl[10] = '{1'b0, 3'd3, 8'h00, 8'h08, 1'b1, 8'h08, 3, 8'h33};
    tbl[11] = '{1'b0, 3'd3, 8'h00, 8'h00, 1'b1, 8'h00, 0, 8'h00};

    #1;
    chk("reset_ov8", 64'(out_valid8), 64'd0);
    chk("reset_irdy8", 64'(in_ready8), 64'd1);
    chk("reset_data8", out_data8, 64'd0);
`ifdef STREAM_DEMUX_ERR_CNT_EN
    chk("reset_err5", 64'(err5), 64'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Table: single word and backpressure on channel 3
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      in_valid8 = tbl[i].iv; in_sel8 = tbl[i].sel; in_data8 = tbl[i].d; out_ready8 = tbl[i].ordy;
      #1;
      chk($sformatf("vec%0d_irdy", i), 64'(in_ready8), 64'(tbl[i].exp_irdy));
      chk($sformatf("vec%0d_ov", i), 64'(out_valid8), 64'(tbl[i].exp_ov));
      if (tbl[i].exp_ov[tbl[i].ch])
        chk($sformatf("vec%0d_data", i), 64'(out_data8[tbl[i].ch*8 +: 8]), 64'(tbl[i].exp_d));
    end

    // Streaming 0x01..0x10 to channel 3 at full rate
    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      in_valid8 = (k < 16); in_sel8 = 3'd3; in_data8 = 8'(k + 1); out_ready8 = 8'h08;
      #1;
      chk("stream_irdy", 64'(in_ready8), 64'd1);
      if (k >= 2 && k < 18) begin
        chk("stream_ov", 64'(out_valid8), 64'h08);
        chk("stream_data", 64'(out_data8[31:24]), 64'(k - 1));
      end else begin
        chk("stream_ov_idle", 64'(out_valid8), 64'h00);
      end
    end

    // Head-of-line blocking behind full channel 2
    @(negedge clk);
    in_valid8 = 1'b1; in_sel8 = 3'd2; in_data8 = 8'hC2; out_ready8 = 8'h00;
    #1 chk("hol_irdy0", 64'(in_ready8), 64'd1);
    @(negedge clk);
    in_data8 = 8'hD2;
    #1 chk("hol_irdy1", 64'(in_ready8), 64'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_sel8 = 3'd6; in_data8 = 8'hE6;
      #1;
      chk("hol_blocked_irdy", 64'(in_ready8), 64'd0);
      chk("hol_blocked_ov", 64'(out_valid8), 64'h04);
    end
    @(negedge clk);
    out_ready8 = 8'h04;
    #1 chk("hol_pulse_irdy", 64'(in_ready8), 64'd1);
    @(negedge clk);
    in_valid8 = 1'b0; out_ready8 = 8'h00;
    #1;
    chk("hol_ov_a", 64'(out_valid8), 64'h04);
    chk("hol_ch2", 64'(out_data8[23:16]), 64'hD2);
    @(negedge clk);
    #1;
    chk("hol_ov_b", 64'(out_valid8), 64'h44);
    chk("hol_ch6", 64'(out_data8[55:48]), 64'hE6);
    @(negedge clk);
    out_ready8 = 8'hFF;
    @(negedge clk);
    #1 chk("hol_drained", 64'(out_valid8), 64'h00);

    // Out-of-range selects on N=5
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      in_valid5 = (k < 4); in_sel5 = (k == 3) ? 3'd1 : 3'd6;
      in_data5 = (k == 3) ? 8'h3C : 8'h99; out_ready5 = 5'h1F;
      #1;
      chk("oor_irdy", 64'(in_ready5), 64'd1);
      if (k == 5) begin
        chk("oor_ov", 64'(out_valid5), 64'h02);
        chk("oor_data", 64'(out_data5[15:8]), 64'h3C);
`ifdef STREAM_DEMUX_ERR_CNT_EN
        chk("oor_err", 64'(err5), 64'd3);
`endif
      end else begin
        chk("oor_ov_none", 64'(out_valid5), 64'h00);
      end
    end

    // Saturation: 300 illegal words
    any_ov = 1'b0;
    for (int k = 0; k < 302; k++) begin
      @(negedge clk);
      in_valid5 = (k < 300); in_sel5 = 3'(5 + (k % 3)); in_data5 = 8'(k);
      #1 any_ov = any_ov | (|out_valid5);
    end
    chk("sat_no_output", 64'(any_ov), 64'd0);
`ifdef STREAM_DEMUX_ERR_CNT_EN
    chk("sat_err", 64'(err5), 64'd255);
`endif

    // Asynchronous reset while words are held
    @(negedge clk);
    in_valid8 = 1'b1; in_sel8 = 3'd1; in_data8 = 8'h5A; out_ready8 = 8'h00;
    in_valid5 = 1'b1; in_sel5 = 3'd2; in_data5 = 8'h77; out_ready5 = 5'h00;
    repeat (2) @(negedge clk);
    #1;
    chk("pre_rst_ov8", 64'(out_valid8), 64'h02);
    chk("pre_rst_irdy8", 64'(in_ready8), 64'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ov8", 64'(out_valid8), 64'h00);
    chk("rst_irdy8", 64'(in_ready8), 64'd1);
    chk("rst_ov5", 64'(out_valid5), 64'h00);
    chk("rst_irdy5", 64'(in_ready5), 64'd1);
`ifdef STREAM_DEMUX_ERR_CNT_EN
    chk("rst_err5", 64'(err5), 64'd0);
`endif
    in_valid8 = 1'b0; out_ready8 = 8'hFF;
    in_valid5 = 1'b0; out_ready5 = 5'h1F;
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic on N=5 against the scoreboard
    drops = 0;
    hold_v = '0;
    for (int i = 0; i < 5; i++) hold_d[i] = '0;
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      in_valid5 = ($urandom_range(0, 9) < 7);
      in_sel5 = 3'($urandom_range(0, 7));
      in_data5 = 8'($urandom);
      out_ready5 = 5'($urandom);
      #1 mon5();
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      in_valid5 = 1'b0; out_ready5 = 5'h1F;
      #1 mon5();
    end
    chk("rand_all_delivered", 64'(sb.size()), 64'd0);
    chk("rand_final_ov", 64'(out_valid5), 64'd0);
`ifdef STREAM_DEMUX_ERR_CNT_EN
    chk("rand_err", 64'(err5), 64'((drops > 255) ? 255 : drops));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
